// File: rtl/axi2ahb_cmd_queue.sv
// AXI AW/AR round-robin front end feeding a command FIFO for an AHB master.
// Each accepted burst is legality-checked and queued with per-cause error flags.
module axi2ahb_cmd_queue #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int CMD_DEPTH      = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [AXI_ID_WIDTH-1:0]   AWID,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [AXI_ID_WIDTH-1:0]   ARID,
    input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic [2:0]                ARSIZE,
    input  logic [1:0]                ARBURST,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [AXI_ID_WIDTH-1:0]   cmd_id_o,
    output logic                      cmd_write_o,
    output logic [AXI_ADDR_WIDTH-1:0] cmd_addr_o,
    output logic [7:0]                cmd_len_o,
    output logic [2:0]                cmd_size_o,
    output logic [1:0]                cmd_burst_o,
    output logic [3:0]                cmd_err_o,
    output logic                      cmd_valid_o,
    input  logic                      cmd_ready_i,
    output logic [$clog2(CMD_DEPTH):0] cmd_count_o
);

    localparam int PW        = $clog2(CMD_DEPTH);
    localparam int CW        = PW + 1;
    localparam int BUS_BYTES = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] BURST_RSVD = 2'b11;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic                      write;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic [3:0]                err;
    } cmd_t;

    cmd_t            mem_q [CMD_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            last_wr_q;

    logic            full, grant_wr, grant_rd, push, pop;
    cmd_t            new_cmd, head;

    // Arbitration and ready gating
    assign full     = (count_q == CW'(CMD_DEPTH));
    assign grant_wr = AWVALID & ~(ARVALID & last_wr_q);
    assign grant_rd = ARVALID & ~grant_wr;
    assign AWREADY  = grant_wr & ~full & ~ARESET;
    assign ARREADY  = grant_rd & ~full & ~ARESET;
    assign push     = AWREADY | ARREADY;
    assign pop      = cmd_valid_o & cmd_ready_i;

    logic [7:0]  beat_bytes;
    logic [6:0]  align_mask;
    logic [13:0] beats14, bytes14, end14;
    logic        len_ok, misalign;

    // Legality check on the granted channel's fields
    always_comb begin
        new_cmd       = '0;
        new_cmd.id    = grant_wr ? AWID    : ARID;
        new_cmd.write = grant_wr;
        new_cmd.addr  = grant_wr ? AWADDR  : ARADDR;
        new_cmd.len   = grant_wr ? AWLEN   : ARLEN;
        new_cmd.size  = grant_wr ? AWSIZE  : ARSIZE;
        new_cmd.burst = grant_wr ? AWBURST : ARBURST;

        beat_bytes = 8'd1 << new_cmd.size;
        align_mask = 7'(beat_bytes - 8'd1);
        misalign   = |(new_cmd.addr[6:0] & align_mask);
        len_ok     = (new_cmd.len == 8'd1) || (new_cmd.len == 8'd3) ||
                     (new_cmd.len == 8'd7) || (new_cmd.len == 8'd15);
        beats14    = 14'(new_cmd.len) + 14'd1;
        bytes14    = beats14 << new_cmd.size;
        end14      = {2'b00, new_cmd.addr[11:0]} + bytes14;

        new_cmd.err[0] = {24'd0, beat_bytes} > 32'(BUS_BYTES);
        new_cmd.err[1] = (new_cmd.burst == BURST_RSVD);
        new_cmd.err[2] = (new_cmd.burst == BURST_WRAP) && (!len_ok || misalign);
        new_cmd.err[3] = (new_cmd.burst == BURST_INCR) && (end14 > 14'd4096);
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            last_wr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + PW'(1);
                last_wr_q <= grant_wr;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Payload storage needs no reset: the head is masked while empty
    always_ff @(posedge ACLK) begin
        if (push && !ARESET)
            mem_q[wr_ptr_q] <= new_cmd;
    end

    assign cmd_valid_o = (count_q != '0);
    assign cmd_count_o = count_q;
    assign head        = cmd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign cmd_id_o    = head.id;
    assign cmd_write_o = head.write;
    assign cmd_addr_o  = head.addr;
    assign cmd_len_o   = head.len;
    assign cmd_size_o  = head.size;
    assign cmd_burst_o = head.burst;
    assign cmd_err_o   = head.err;

endmodule

// File: tb/tb_axi2ahb_cmd_queue.sv
// Randomized and directed checks of axi2ahb_cmd_queue against a queue-based model.
module tb_axi2ahb_cmd_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    typedef struct packed {
        logic [3:0]  id;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  err;
    } cmd_t;

    logic        ACLK = 0, ARESET = 1;
    logic [3:0]  AWID = 0, ARID = 0;
    logic [31:0] AWADDR = 0, ARADDR = 0;
    logic [7:0]  AWLEN = 0, ARLEN = 0;
    logic [2:0]  AWSIZE = 0, ARSIZE = 0;
    logic [1:0]  AWBURST = 0, ARBURST = 0;
    logic        AWVALID = 0, ARVALID = 0, AWREADY, ARREADY;
    logic [3:0]  cmd_id_o, cmd_err_o;
    logic        cmd_write_o, cmd_valid_o, cmd_ready_i = 0;
    logic [31:0] cmd_addr_o;
    logic [7:0]  cmd_len_o;
    logic [2:0]  cmd_size_o;
    logic [1:0]  cmd_burst_o;
    logic [2:0]  cmd_count_o;

    axi2ahb_cmd_queue #(.AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(DW),
                        .CMD_DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .cmd_id_o(cmd_id_o), .cmd_write_o(cmd_write_o), .cmd_addr_o(cmd_addr_o),
        .cmd_len_o(cmd_len_o), .cmd_size_o(cmd_size_o), .cmd_burst_o(cmd_burst_o),
        .cmd_err_o(cmd_err_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_count_o(cmd_count_o)
    );

    always #5 ACLK = ~ACLK;

    int   n_chk = 0, n_err = 0;
    cmd_t q[$];
    bit   lg_wr = 0;
    int   hs = 0;   // handshake of last cycle: 0 none, 1 write, 2 read

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_err(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
        int bytes = 1 << size;
        logic [3:0] e = 0;
        e[0] = bytes > DW / 8;
        e[1] = burst == 2'b11;
        e[2] = burst == 2'b10 && (!(len inside {1, 3, 7, 15}) || (addr % bytes) != 0);
        e[3] = burst == 2'b01 && ((((addr & 32'hfff) + ((int'(len) + 1) << size)) % 16384) > 4096);
        return e;
    endfunction

    function automatic cmd_t dut_head();
        return {cmd_id_o, cmd_write_o, cmd_addr_o, cmd_len_o, cmd_size_o, cmd_burst_o, cmd_err_o};
    endfunction

    // One clock: check outputs at negedge, advance model, return 1 time unit after posedge
    task automatic cycle();
        bit full, gw, gr;
        cmd_t e;
        @(negedge ACLK);
        full = q.size() == DEPTH;
        gw = AWVALID && !(ARVALID && lg_wr);
        gr = ARVALID && !gw;
        hs = 0;
        if (ARESET) begin
            chk("rst_ready", {AWREADY, ARREADY}, 0);
            q.delete();
            lg_wr = 0;
        end else begin
            chk("awready", AWREADY, gw && !full);
            chk("arready", ARREADY, gr && !full);
            chk("valid", cmd_valid_o, q.size() != 0);
            chk("count", cmd_count_o, q.size());
            if (q.size() != 0) chk("head", dut_head(), q[0]);
            if (q.size() != 0 && cmd_ready_i) void'(q.pop_front());
            if (!full && (gw || gr)) begin
                if (gw) e = {AWID, 1'b1, AWADDR, AWLEN, AWSIZE, AWBURST, 4'h0};
                else    e = {ARID, 1'b0, ARADDR, ARLEN, ARSIZE, ARBURST, 4'h0};
                e.err = model_err(e.addr, e.len, e.size, e.burst);
                q.push_back(e);
                lg_wr = gw;
                hs = gw ? 1 : 2;
            end
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic rand_fields(output logic [3:0] id, output logic [31:0] addr,
                               output logic [7:0] len, output logic [2:0] size,
                               output logic [1:0] burst);
        int k;
        id    = 4'($urandom);
        size  = 3'($urandom_range(0, 7));
        burst = 2'($urandom);
        k     = $urandom_range(0, 5);
        len   = (k == 5) ? 8'($urandom) : 8'((1 << k) - 1);
        addr  = $urandom;
        if ($urandom_range(0, 1)) addr[11:0] = 12'hf00 | 12'($urandom_range(0, 255));
        if (burst != 2'b10) addr = addr & ~((32'd1 << size) - 1);
    endtask

    task automatic do_ar(input string tag, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b, input logic [3:0] exp);
        ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = b; ARVALID = 1;
        cycle();
        ARVALID = 0;
        chk(tag, cmd_err_o, exp);
        cmd_ready_i = 1; cycle(); cmd_ready_i = 0;
    endtask

    task automatic do_aw(input string tag, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b, input logic [3:0] exp);
        AWADDR = a; AWLEN = l; AWSIZE = s; AWBURST = b; AWVALID = 1;
        cycle();
        AWVALID = 0;
        chk(tag, cmd_err_o, exp);
        cmd_ready_i = 1; cycle(); cmd_ready_i = 0;
    endtask

    initial begin
        logic [3:0] order;
        ARESET = 1;
        cycle(); cycle();
        ARESET = 0;
        chk("rst_valid", cmd_valid_o, 0);
        chk("rst_count", cmd_count_o, 0);
        chk("rst_payload", dut_head(), 0);

        // Single write after reset
        AWID = 4'h5; AWADDR = 32'h100; AWLEN = 3; AWSIZE = 2; AWBURST = 2'b01; AWVALID = 1;
        #1 chk("t1_awready", AWREADY, 1);
        cycle();
        AWVALID = 0;
        chk("t1_valid", cmd_valid_o, 1);
        chk("t1_write", cmd_write_o, 1);
        chk("t1_addr", cmd_addr_o, 32'h100);
        chk("t1_len", cmd_len_o, 3);
        chk("t1_err", cmd_err_o, 0);
        chk("t1_count", cmd_count_o, 1);
        cmd_ready_i = 1; cycle(); cmd_ready_i = 0;

        // Contention fills the FIFO in alternating order
        ARESET = 1; cycle(); ARESET = 0;
        ARID = 4'h9; ARADDR = 32'h2000; ARLEN = 1; ARSIZE = 1; ARBURST = 2'b01;
        AWVALID = 1; ARVALID = 1;
        order = 0;
        repeat (4) begin
            cycle();
            order = {order[2:0], hs == 1};
        end
        chk("t2_order", order, 4'b1010);
        chk("t2_count", cmd_count_o, 4);
        chk("t2_full_rdy", {AWREADY, ARREADY}, 0);
        ARVALID = 0;

        // Pop on full: no push that cycle, push the next
        cmd_ready_i = 1;
        #1 chk("t3_aw_blocked", AWREADY, 0);
        cycle();
        cmd_ready_i = 0;
        chk("t3_pop_hs", hs, 0);
        chk("t3_count3", cmd_count_o, 3);
        cycle();
        chk("t3_push_hs", hs, 1);
        chk("t3_count4", cmd_count_o, 4);
        AWVALID = 0;
        cmd_ready_i = 1; repeat (4) cycle(); cmd_ready_i = 0;

        // Error flag causes
        do_ar("e_size", 32'h0,   8'd0, 3'd3, 2'b01, 4'b0001);
        do_ar("e_rsvd", 32'h0,   8'd0, 3'd2, 2'b11, 4'b0010);
        do_ar("e_wlen", 32'h0,   8'd5, 3'd2, 2'b10, 4'b0100);
        do_ar("e_walg", 32'h102, 8'd3, 3'd2, 2'b10, 4'b0100);
        do_aw("e_4k",   32'hff0, 8'd7, 3'd2, 2'b01, 4'b1000);
        do_aw("e_no4k", 32'hfe0, 8'd7, 3'd2, 2'b01, 4'b0000);

        // Reset with queued entries, then write wins first contention
        AWVALID = 1; repeat (3) cycle(); AWVALID = 0;
        chk("t5_count3", cmd_count_o, 3);
        ARESET = 1; cycle(); ARESET = 0;
        chk("t5_valid", cmd_valid_o, 0);
        chk("t5_count", cmd_count_o, 0);
        AWVALID = 1; ARVALID = 1;
        #1 chk("t5_grant", {AWREADY, ARREADY}, 2'b10);
        cycle();
        AWVALID = 0; ARVALID = 0;
        cmd_ready_i = 1; cycle(); cmd_ready_i = 0;

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (!AWVALID && $urandom_range(0, 1)) begin
                rand_fields(AWID, AWADDR, AWLEN, AWSIZE, AWBURST);
                AWVALID = 1;
            end
            if (!ARVALID && $urandom_range(0, 1)) begin
                rand_fields(ARID, ARADDR, ARLEN, ARSIZE, ARBURST);
                ARVALID = 1;
            end
            cmd_ready_i = $urandom_range(0, 2) == 0;
            ARESET = $urandom_range(0, 199) == 0;
            cycle();
            ARESET = 0;
            if (hs == 1) AWVALID = 0;
            if (hs == 2) ARVALID = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axi2ahb_cmd_queue.md
Name: axi2ahb_cmd_queue

Overview:
Next-generation AXI-to-AHB command front end.
- Arbitrates the AXI write-address (AW) and read-address (AR) channels round-robin.
- Legality-checks each burst against the configured data width, then queues the decoded command in a parametrised FIFO for the AHB master controller.
- Generalises the single-register command stage: full address, full 8-bit length, any data width, multi-entry buffering, and per-cause error flags.

Parameters:
AXI_ID_WIDTH, 4, width of AWID/ARID and cmd_id_o
AXI_ADDR_WIDTH, 32, width of AWADDR/ARADDR and cmd_addr_o
AXI_DATA_WIDTH, 32, data bus width in bits (32/64/128); sets max legal AxSIZE
CMD_DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  reset, synchronous, active-high
AWID  in  AXI_ID_WIDTH  write ID
AWADDR  in  AXI_ADDR_WIDTH  write start address
AWLEN  in  8  write beats minus 1
AWSIZE  in  3  write beat size log2(bytes)
AWBURST  in  2  write burst type
AWVALID  in  1  AW valid
AWREADY  out  1  AW ready
ARID  in  AXI_ID_WIDTH  read ID
ARADDR  in  AXI_ADDR_WIDTH  read start address
ARLEN  in  8  read beats minus 1
ARSIZE  in  3  read beat size
ARBURST  in  2  read burst type
ARVALID  in  1  AR valid
ARREADY  out  1  AR ready
cmd_id_o  out  AXI_ID_WIDTH  head command ID
cmd_write_o  out  1  head is write (0 = read)
cmd_addr_o  out  AXI_ADDR_WIDTH  head start address
cmd_len_o  out  8  head AxLEN
cmd_size_o  out  3  head AxSIZE
cmd_burst_o  out  2  head AxBURST
cmd_err_o  out  4  head error flags {cross4k, wraplen, rsvd_burst, size}
cmd_valid_o  out  1  FIFO non-empty
cmd_ready_i  in  1  consumer pops head when cmd_valid_o & cmd_ready_i
cmd_count_o  out  $clog2(CMD_DEPTH)+1  entries held

Behaviour:
- Reset (ARESET high at a rising edge):
  - count = 0; FIFO pointers = 0; last_grant = read.
  - cmd_valid_o = 0; AWREADY = ARREADY = 0.
  - All cmd_* payload outputs = 0.
  - Reset mid-burst discards all queued entries; no pop is signalled.
- Arbitration (combinational, from AWVALID, ARVALID, last_grant):
  - Only AWVALID: grant write. Only ARVALID: grant read.
  - Both valid: grant the channel opposite last_grant.
  - last_grant updates only on an accepted push.
- Ready rules:
  - AWREADY = grant_write & !full; ARREADY = grant_read & !full.
  - Never both high in one cycle.
  - At most one push per cycle.
  - full = (count == CMD_DEPTH).
- Push stores {ID, write flag, addr, len, size, burst, err} of the granted channel.
  - Entry is visible at the head on the cycle after the handshake.
  - Latency push-to-cmd_valid_o = 1 cycle when empty.
- Pop: cmd_* outputs show the head entry (registered/FIFO read, not combinational from AXI inputs). The head advances on cmd_valid_o & cmd_ready_i.
- Simultaneous push and pop:
  - Count unchanged.
  - When full, ready stays low that cycle; a push is not accepted on the pop cycle. Space appears next cycle.
- Pointer wrap: modulo CMD_DEPTH; count is exact from 0 to CMD_DEPTH.
- Errors are computed at push from the granted inputs; a flagged command is still queued:
  - size: (1<<AxSIZE) > AXI_DATA_WIDTH/8.
  - rsvd_burst: AxBURST == 2'b11.
  - wraplen: AxBURST == WRAP and AxLEN not in {1,3,7,15}, or addr not aligned to (1<<AxSIZE).
  - cross4k: AxBURST == INCR and addr[11:0] + ((AxLEN+1)<<AxSIZE) > 4096, computed with 14-bit arithmetic.
  - FIXED bursts never set cross4k.
- An AXI handshake, once valid is high, is not withdrawn by this block. Input stability while valid & !ready is the master's obligation.

Test Plan:
- Reset then AWVALID, AWADDR=0x100, AWLEN=3, AWSIZE=2, AWBURST=INCR -> AWREADY=1 in that cycle; next cycle cmd_valid_o=1, cmd_write_o=1, cmd_addr_o=0x100, cmd_len_o=3, cmd_err_o=0, cmd_count_o=1.
- AWVALID & ARVALID held for 4 pushes, cmd_ready_i=0 -> grant order W,R,W,R; cmd_count_o=4; AWREADY=ARREADY=0 afterwards (full).
- Full FIFO, cmd_ready_i=1 one cycle with AWVALID held -> pop that cycle with no push; push accepted next cycle; count 4→3→4.
- AR with ARSIZE=3 (DATA_WIDTH=32) -> cmd_err_o=4'b0001. ARBURST=2'b11 -> 4'b0010. WRAP with ARLEN=5 -> 4'b0100. WRAP with ARLEN=3, ARADDR=0x102, ARSIZE=2 -> 4'b0100.
- INCR with AWADDR=0xFF0, AWLEN=7, AWSIZE=2 (32 B) -> cmd_err_o=4'b1000. Same command with AWADDR=0xFE0 -> 0.
- ARESET asserted with 3 entries queued -> next cycle cmd_valid_o=0, cmd_count_o=0. First contention after reset is granted to write.
